push_button_debouncer: RTL and testbench
========================================

# push_button_debouncer

Conditions raw DE10-Lite KEY inputs before they reach the push-button PIO's `in_port`. Each channel is synchronised, polarity-normalised and debounced by a per-channel stable-time counter. The block drives `btn_clean`, which connects directly to the PIO `in_port`. It also emits one-cycle press/release strobes for hardware consumers that bypass the PIO.

## Interface
- `WIDTH`, 2: number of button channels.
- `STABLE_CYCLES`, 500000: consecutive agreeing samples required to accept a new level (10 ms at 50 MHz). Legal range ≥ 2.
- `ACTIVE_LOW`, 1: 1 means `btn_raw` reads 0 when pressed; 0 means it reads 1 when pressed.
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `btn_raw` in WIDTH: asynchronous button pins.
- `btn_clean` out WIDTH: debounced level, 1 = pressed. Feeds PIO `in_port`.
- `press_pulse` out WIDTH: one-cycle strobe when `btn_clean[i]` rises.
- `release_pulse` out WIDTH: one-cycle strobe when `btn_clean[i]` falls.

## Operation
- **Synchroniser:** two flops per channel, `sync1 → sync2`. Reset value is the released pin level: all 1 if `ACTIVE_LOW`, else all 0.
- **Normalisation:** `lvl[i] = sync2[i] ^ ACTIVE_LOW`, so 1 always means pressed.
- **Per-channel FSM:** states IDLE and CHECK, plus a counter `cnt` of width `$clog2(STABLE_CYCLES)`.
  - IDLE:
    - If `lvl == btn_clean`, stay in IDLE with `cnt = 0`.
    - Otherwise go to CHECK with `cnt = 1`.
  - CHECK:
    - If `lvl == btn_clean` (bounce back), go to IDLE with `cnt = 0`. No output change.
    - Else if `cnt == STABLE_CYCLES-1`, toggle `btn_clean`, strobe the matching pulse for one cycle, go to IDLE with `cnt = 0`.
    - Else increment `cnt`.
- **Acceptance rule:** exactly `STABLE_CYCLES` consecutive samples of `lvl` differing from `btn_clean` toggle the output. Any single agreeing sample restarts qualification.
- **Counter bounds:** the counter never exceeds `STABLE_CYCLES-1` and never wraps.
- **Channel independence:** channels run fully independently. Simultaneous qualification on several channels yields simultaneous pulses.
- **Pulse exclusivity:** `press_pulse[i]` and `release_pulse[i]` are never both 1.
  - A channel pulses at most once per `STABLE_CYCLES` cycles.
- **Reset mid-qualification:** abandons the count. After reset, a button still held is re-qualified from zero and produces a press pulse.

## Timing
- **Reset values:**
  - `btn_clean = 0`, `press_pulse = 0`, `release_pulse = 0`.
  - All FSMs in IDLE, all `cnt = 0`.
  - Synchronisers at the released level.
- **Latency:** a clean raw transition sampled at edge k appears in `sync2` at edge k+1. The FSM enters CHECK at edge k+2. `btn_clean` and the pulse update at edge k+1+`STABLE_CYCLES`, i.e. `STABLE_CYCLES`+1 cycles after first sampling.
- **Output registering:** all outputs are registered, with no combinational path from `btn_raw`.
- **Pulse width:** pulses are high for exactly one `clk` cycle, aligned with the `btn_clean` edge.
- **PIO interaction:** the PIO adds its own two-flop edge detector. `edge_capture` sets 2 cycles after `btn_clean` rises.

## Structure
- **Package `push_button_pkg`:**
  - `db_state_t` enum (IDLE, CHECK).
  - `DEFAULT_STABLE_CYCLES` = 500000.
  - `SIM_STABLE_CYCLES` = 16.
- **Sub-module `debounce_channel`:** one instance per channel via generate. It holds the synchroniser, FSM, counter and pulse registers, and is parameterised by `STABLE_CYCLES` and `ACTIVE_LOW`.
- **Top level:** the generate loop and port concatenation only.

## Test plan
All tests use `STABLE_CYCLES=16`, `ACTIVE_LOW=1`, `WIDTH=2`.
- **Reset:** hold `reset_n=0` with `btn_raw=2'b11` → all outputs 0. Release reset, keep 11 for 100 cycles → no pulses.
- **Clean press:** `btn_raw[0]` 1→0 at edge k → `btn_clean[0]` rises and `press_pulse[0]=1` for one cycle at edge k+17. Then `btn_raw[0]` 0→1 → `release_pulse[0]` fires 17 cycles later and `btn_clean[0]` falls.
- **Bounce:** `btn_raw[1]` toggles low 10 cycles, high 1, low 10, high 1, then low steady → exactly one `press_pulse[1]`, 17 cycles after the final low edge, no release pulse.
- **Near-miss:** `btn_raw[0]` low for 15 samples then high → no output change, no pulse. Low for exactly 16 samples → press accepted.
- **Simultaneous:** both bits 11→00 at the same edge → `press_pulse=2'b11` in the same cycle.
- **Reset mid-qualification:** assert `reset_n` 8 cycles into CHECK with the button held → outputs 0. After release, a press pulse occurs 17 cycles later.

Source files
------------

// File: rtl/push_button_pkg.sv
// Shared types and constants for the push-button debouncer.
package push_button_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CHECK = 1'b1
    } db_state_t;

    localparam int DEFAULT_STABLE_CYCLES = 500000;  // 10 ms at 50 MHz
    localparam int SIM_STABLE_CYCLES     = 16;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchroniser, polarity normalisation,
// stable-time qualification FSM and registered press/release strobes.
module debounce_channel
    import push_button_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_raw_i,
    output logic btn_clean_o,
    output logic press_pulse_o,
    output logic release_pulse_o
);

    localparam int              CNT_W   = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             lvl;
    db_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clean_q, clean_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    // Synchroniser resets to the released pin level so no phantom press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= ACTIVE_LOW;
            sync2_q <= ACTIVE_LOW;
        end else begin
            sync1_q <= btn_raw_i;
            sync2_q <= sync1_q;
        end
    end

    assign lvl = sync2_q ^ ACTIVE_LOW;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            clean_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            clean_q   <= clean_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        clean_d   = clean_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (lvl == clean_q) begin
                    cnt_d = '0;
                end else begin
                    state_d = CHECK;
                    cnt_d   = CNT_W'(1);
                end
            end
            CHECK: begin
                if (lvl == clean_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    // Counter stops here, so it can never pass CNT_MAX or wrap.
                    state_d   = IDLE;
                    cnt_d     = '0;
                    clean_d   = ~clean_q;
                    press_d   = ~clean_q;
                    release_d = clean_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign btn_clean_o     = clean_q;
    assign press_pulse_o   = press_q;
    assign release_pulse_o = release_q;

endmodule

// File: rtl/push_button_debouncer.sv
// Debounces the KEY pins feeding the push-button PIO; one independent
// debounce_channel per button.
module push_button_debouncer
    import push_button_pkg::*;
#(
    parameter int WIDTH         = 2,
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] btn_raw,
    output logic [WIDTH-1:0] btn_clean,
    output logic [WIDTH-1:0] press_pulse,
    output logic [WIDTH-1:0] release_pulse
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .ACTIVE_LOW    (ACTIVE_LOW)
        ) u_ch (
            .clk             (clk),
            .reset_n         (reset_n),
            .btn_raw_i       (btn_raw[i]),
            .btn_clean_o     (btn_clean[i]),
            .press_pulse_o   (press_pulse[i]),
            .release_pulse_o (release_pulse[i])
        );
    end

endmodule

// File: tb/tb_push_button_debouncer.sv
// Directed bench: stimulus queues expected pulse events, a negedge monitor
// pops and checks them whenever the DUT emits a strobe.
module tb_push_button_debouncer;
    import push_button_pkg::*;

    localparam int SC  = SIM_STABLE_CYCLES;
    localparam int LAT = SC + 1;

    typedef struct {
        int         cyc;
        logic [1:0] pr;
        logic [1:0] rl;
        logic [1:0] cl;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] btn_raw = 2'b11;
    logic [1:0] btn_clean, press_pulse, release_pulse;

    int  cyc = 0;
    int  total = 0;
    int  bad = 0;
    ev_t sb[$];

    push_button_debouncer #(
        .WIDTH         (2),
        .STABLE_CYCLES (SC),
        .ACTIVE_LOW    (1'b1)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .btn_raw       (btn_raw),
        .btn_clean     (btn_clean),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    // Monitor: every strobe must match the oldest expected event exactly.
    always @(negedge clk) begin
        if ((press_pulse | release_pulse) != 2'b00) begin
            total = total + 1;
            if (sb.size() == 0) begin
                bad = bad + 1;
                $display("FAIL unexpected_pulse cyc=%0d press=%b release=%b clean=%b",
                         cyc, press_pulse, release_pulse, btn_clean);
            end else begin
                ev_t e;
                e = sb.pop_front();
                if (e.cyc != cyc || e.pr != press_pulse || e.rl != release_pulse ||
                    e.cl != btn_clean) begin
                    bad = bad + 1;
                    $display("FAIL pulse_event got cyc=%0d pr=%b rl=%b cl=%b want cyc=%0d pr=%b rl=%b cl=%b",
                             cyc, press_pulse, release_pulse, btn_clean,
                             e.cyc, e.pr, e.rl, e.cl);
                end
            end
        end
    end

    // Drive after a posedge; k is the edge that first samples the new value.
    task automatic drive(input logic [1:0] v, output int k);
        @(posedge clk);
        #1;
        btn_raw = v;
        k = cyc + 1;
    endtask

    task automatic expect_ev(input int k, input logic [1:0] pr, input logic [1:0] rl,
                             input logic [1:0] cl);
        ev_t e;
        e.cyc = k + LAT;
        e.pr  = pr;
        e.rl  = rl;
        e.cl  = cl;
        sb.push_back(e);
    endtask

    // Keep the current value for n sampling edges in total.
    task automatic hold(input int n);
        repeat (n - 1) @(posedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%b want=%b", name, act, exp);
        end
    endtask

    initial begin
        int k;
        // Reset with buttons released
        idle(3);
        @(negedge clk);
        chk("rst_clean", btn_clean, 2'b00);
        chk("rst_press", press_pulse, 2'b00);
        chk("rst_release", release_pulse, 2'b00);
        @(posedge clk);
        #1 reset_n = 1'b1;
        idle(100);

        // Clean press and release on channel 0
        drive(2'b10, k);
        expect_ev(k, 2'b01, 2'b00, 2'b01);
        idle(30);
        drive(2'b11, k);
        expect_ev(k, 2'b00, 2'b01, 2'b00);
        idle(30);

        // Bouncing press on channel 1
        drive(2'b01, k); hold(10);
        drive(2'b11, k); hold(1);
        drive(2'b01, k); hold(10);
        drive(2'b11, k); hold(1);
        drive(2'b01, k);
        expect_ev(k, 2'b10, 2'b00, 2'b10);
        idle(30);
        drive(2'b11, k);
        expect_ev(k, 2'b00, 2'b10, 2'b00);
        idle(30);

        // Near-miss: 15 low samples must not qualify
        drive(2'b10, k); hold(SC - 1);
        drive(2'b11, k);
        idle(30);
        @(negedge clk);
        chk("nearmiss_clean", btn_clean, 2'b00);

        // Exactly 16 low samples qualify; releasing right away then releases
        drive(2'b10, k);
        expect_ev(k, 2'b01, 2'b00, 2'b01);
        hold(SC);
        drive(2'b11, k);
        expect_ev(k, 2'b00, 2'b01, 2'b00);
        idle(30);

        // Simultaneous press and release on both channels
        drive(2'b00, k);
        expect_ev(k, 2'b11, 2'b00, 2'b11);
        idle(30);
        drive(2'b11, k);
        expect_ev(k, 2'b00, 2'b11, 2'b00);
        idle(30);

        // Reset 8 cycles into qualification with the button held
        drive(2'b10, k);
        idle(10);
        #1 reset_n = 1'b0;
        @(negedge clk);
        chk("midrst_clean", btn_clean, 2'b00);
        chk("midrst_press", press_pulse, 2'b00);
        chk("midrst_release", release_pulse, 2'b00);
        idle(2);
        @(posedge clk);
        #1 reset_n = 1'b1;
        expect_ev(cyc + 1, 2'b01, 2'b00, 2'b01);
        idle(30);
        drive(2'b11, k);
        expect_ev(k, 2'b00, 2'b01, 2'b00);
        idle(40);

        total = total + 1;
        if (sb.size() != 0) begin
            bad = bad + 1;
            $display("FAIL missing_events got=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
